// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants for the board-input conditioning block: clock rate, default
// debounce/auto-repeat timing in clk_50 cycles, and the channel index map.
// Optional feature macro used by the block: DEBOUNCE_REPEAT_EN (auto-repeat).
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_MS_DEFAULT = 20;

    localparam int N_IN_DEFAULT            = 5;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT;
    localparam int REPEAT_DELAY_DEFAULT    = (CLK_HZ / 1000) * 500;
    localparam int REPEAT_PERIOD_DEFAULT   = (CLK_HZ / 1000) * 100;

    // Channel map: buttons occupy [1:0], DIP switches [4:2]
    localparam int BTN_LSB   = 0;
    localparam int DIPSW_LSB = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_if.sv
// -----------------------------------------------------------------------------
// debounce_if
// Bundles the raw pad inputs and the conditioned outputs of debounce_inputs.
//   raw_n         : raw active-low pad levels (asynchronous to clk_50)
//   level         : debounced active-high state
//   press         : one-cycle pulse on debounced 0->1 (and on auto-repeat)
//   release_pulse : one-cycle pulse on debounced 1->0
//   any_change    : OR of all press/release bits, aligned with them
// Modports: master = the debouncer, slave = board/consumer side.
// -----------------------------------------------------------------------------
interface debounce_if
    import debounce_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
);
    logic [N_IN-1:0] raw_n;
    logic [N_IN-1:0] level;
    logic [N_IN-1:0] press;
    logic [N_IN-1:0] release_pulse;
    logic            any_change;

    modport master (
        input  raw_n,
        output level,
        output press,
        output release_pulse,
        output any_change
    );

    modport slave (
        output raw_n,
        input  level,
        input  press,
        input  release_pulse,
        input  any_change
    );
endinterface

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One input channel: 2-flop synchronizer, stable-time debounce counter and
// registered press/release pulse generation. With DEBOUNCE_REPEAT_EN defined,
// a held press re-pulses after REPEAT_DELAY cycles, then every REPEAT_PERIOD.
// Ports:
//   clk_50, rst_n  : clock, asynchronous active-low reset
//   raw_n          : raw active-low pad input
//   level          : debounced active-high level
//   press          : one-cycle press pulse (registered, aligned with level)
//   release_pulse  : one-cycle release pulse (registered, aligned with level)
//   pulse_nxt      : next-cycle value of press|release_pulse, lets the parent
//                    register any_change in step with the pulses
// -----------------------------------------------------------------------------
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic pulse_nxt
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("debounce_chan: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("debounce_chan: repeat timing must be >= 1");
    end

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          s;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt, press_nxt, rel_nxt;
    logic          rep_hit;

    assign s = ~sync2;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int            RW        = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic          rep_armed;   // first repeat already issued: use the period

    assign rep_hit = level && (rcnt == (rep_armed ? REP_NEXT : REP_FIRST));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rcnt      <= '0;
            rep_armed <= 1'b0;
        end else if (!level) begin
            rcnt      <= '0;
            rep_armed <= 1'b0;
        end else if (rep_hit) begin
            rcnt      <= '0;
            rep_armed <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        if (s == level) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            level_nxt = s;
            press_nxt = s;
            rel_nxt   = ~s;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        // A repeat press never coincides with the release that ends the hold
        if (rep_hit && !rel_nxt) begin
            press_nxt = 1'b1;
        end
    end

    assign pulse_nxt = press_nxt | rel_nxt;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            level         <= level_nxt;
            press         <= press_nxt;
            release_pulse <= rel_nxt;
        end
    end

endmodule

// File: rtl/debounce_inputs.sv
// -----------------------------------------------------------------------------
// debounce_inputs
// Conditions the active-low board inputs (buttons at BTN_LSB, DIP switches at
// DIPSW_LSB) into clean active-high levels plus press/release pulses in the
// clk_50 domain. One debounce_chan per channel; any_change is registered so it
// lines up with the per-channel pulses.
// Optional feature: define DEBOUNCE_REPEAT_EN for press auto-repeat.
// Ports:
//   clk_50 : 50 MHz system clock
//   rst_n  : asynchronous active-low reset
//   bus    : debounce_if.master (raw_n in; level/press/release_pulse/any_change out)
// -----------------------------------------------------------------------------
module debounce_inputs
    import debounce_pkg::*;
#(
    parameter int N_IN            = N_IN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic       clk_50,
    input  logic       rst_n,
    debounce_if.master bus
);

    logic [N_IN-1:0] level_v;
    logic [N_IN-1:0] press_v;
    logic [N_IN-1:0] rel_v;
    logic [N_IN-1:0] pulse_nxt;
    logic            any_change_r;

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk_50        (clk_50),
            .rst_n         (rst_n),
            .raw_n         (bus.raw_n[i]),
            .level         (level_v[i]),
            .press         (press_v[i]),
            .release_pulse (rel_v[i]),
            .pulse_nxt     (pulse_nxt[i])
        );
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            any_change_r <= 1'b0;
        end else begin
            any_change_r <= |pulse_nxt;
        end
    end

    assign bus.level         = level_v;
    assign bus.press         = press_v;
    assign bus.release_pulse = rel_v;
    assign bus.any_change    = any_change_r;

endmodule

// File: tb/tb_debounce_inputs.sv
// -----------------------------------------------------------------------------
// tb_debounce_inputs
// Directed bench for debounce_inputs with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5. Inputs change 1 ns after an edge; a change made after edge
// t shows up on level/pulses after edge t+6 (2 sync + 4 debounce cycles).
// Expected auto-repeat behaviour follows DEBOUNCE_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_debounce_inputs;

    localparam int N = 5;

`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    debounce_if #(.N_IN(N)) bus ();

    debounce_inputs #(
        .N_IN            (N),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 clk_50 = ~clk_50;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    // packed view: {level, press, release_pulse, any_change}
    function automatic logic [3*N:0] obs();
        return {bus.level, bus.press, bus.release_pulse, bus.any_change};
    endfunction

    task automatic test_reset();
        logic [3*N:0] exp_v;
        rst_n      = 1'b0;
        bus.raw_n  = 5'b11111;
        exp_v      = '0;
        step();
        step();
        n_cmp++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL reset_hold: got %b want %b", obs(), exp_v);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL reset_idle k=%0d: got %b want %b", k, obs(), exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3*N:0] exp_v;
        bus.raw_n[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = {(k >= 6) ? 5'b00001 : 5'b00000,
                     (k == 6) ? 5'b00001 : 5'b00000,
                     5'b00000,
                     (k == 6)};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL clean_press k=%0d: got %b want %b", k, obs(), exp_v);
            end
        end
        bus.raw_n[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = {(k < 6) ? 5'b00001 : 5'b00000,
                     5'b00000,
                     (k == 6) ? 5'b00001 : 5'b00000,
                     (k == 6)};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL clean_release k=%0d: got %b want %b", k, obs(), exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3*N:0] exp_v;
        exp_v = '0;
        for (int seg = 0; seg < 10; seg++) begin
            bus.raw_n[1] = (seg % 2 == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 2; c++) begin
                step();
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_err++;
                    $display("FAIL bounce seg=%0d: got %b want %b", seg, obs(), exp_v);
                end
            end
        end
        bus.raw_n[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = {(k >= 6) ? 5'b00010 : 5'b00000,
                     (k == 6) ? 5'b00010 : 5'b00000,
                     5'b00000,
                     (k == 6)};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL bounce_settle k=%0d: got %b want %b", k, obs(), exp_v);
            end
        end
        bus.raw_n[1] = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_simultaneous();
        logic [3*N:0] exp_v;
        bus.raw_n[2] = 1'b0;
        bus.raw_n[4] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = {(k >= 6) ? 5'b10100 : 5'b00000,
                     (k == 6) ? 5'b10100 : 5'b00000,
                     5'b00000,
                     (k == 6)};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL simul_press k=%0d: got %b want %b", k, obs(), exp_v);
            end
        end
        bus.raw_n[2] = 1'b1;
        bus.raw_n[4] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = {(k < 6) ? 5'b10100 : 5'b00000,
                     5'b00000,
                     (k == 6) ? 5'b10100 : 5'b00000,
                     (k == 6)};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL simul_release k=%0d: got %b want %b", k, obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3*N:0] exp_v;
        // park a DIP switch on so the reset has a level to clear
        bus.raw_n[3] = 1'b0;
        repeat (8) step();
        exp_v = {5'b01000, 5'b00000, 5'b00000, 1'b0};
        n_cmp++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL mid_pre: got %b want %b", obs(), exp_v);
        end
        bus.raw_n[0] = 1'b0;
        repeat (4) step();     // channel 0 counter now at 2
        rst_n = 1'b0;
        #1;
        exp_v = '0;
        n_cmp++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL mid_async_clear: got %b want %b", obs(), exp_v);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = {(k >= 6) ? 5'b01001 : 5'b00000,
                     (k == 6) ? 5'b01001 : 5'b00000,
                     5'b00000,
                     (k == 6)};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL mid_after k=%0d: got %b want %b", k, obs(), exp_v);
            end
        end
        bus.raw_n[0] = 1'b1;
        bus.raw_n[3] = 1'b1;
        repeat (8) step();
        exp_v = '0;
        n_cmp++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL mid_cleanup: got %b want %b", obs(), exp_v);
        end
    endtask

    task automatic test_repeat();
        logic [3*N:0] exp_v;
        logic         lvl, prs, rel;
        bus.raw_n[0] = 1'b0;
        repeat (5) step();
        step();                // edge p: debounced press
        exp_v = {5'b00001, 5'b00001, 5'b00000, 1'b1};
        n_cmp++;
        if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL repeat_first: got %b want %b", obs(), exp_v);
        end
        for (int m = 1; m <= 50; m++) begin
            step();
            if (m == 40) bus.raw_n[0] = 1'b1;
            lvl = (m < 46);
            rel = (m == 46);
            prs = REP_EN && lvl && ((m == 10) || (m > 10 && (m - 10) % 5 == 0));
            exp_v = {4'b0000, lvl, 4'b0000, prs, 4'b0000, rel, prs | rel};
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++;
                $display("FAIL repeat m=%0d: got %b want %b", m, obs(), exp_v);
            end
        end
    endtask

    initial begin
        bus.raw_n = 5'b11111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
